// File: rtl/result_sender_pkg.sv
// Shared definitions for the result sender: FSM state type, frame delimiters
// and the result element width used by the MAC array and result buffer.
package result_sender_pkg;

  localparam int RESULT_W = 16;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hFE;
  localparam logic [7:0] TRL_BYTE_DEF = 8'hEF;

  typedef enum logic [3:0] {
    IDLE,
    HDR,
    FETCH,
    RDWAIT,
    SEND_HI,
    SEND_LO,
    CHK,
    TRL,
    DONE_S
  } sender_state_t;

endpackage

// File: rtl/result_sender_tx_byte_hs.sv
// Single-byte UART handshake: pulse TX_START while the UART is idle, wait for
// busy to rise and fall, then report byte_done for one cycle.
module tx_byte_hs (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       req,
  input  logic [7:0] byte_in,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       byte_done
);

  typedef enum logic [1:0] {HS_IDLE, HS_WAIT_HI, HS_WAIT_LO} hs_state_t;

  hs_state_t hs_q, hs_d;
  logic      pulse_q;
  logic      fire;

  always_comb begin
    hs_d      = hs_q;
    fire      = 1'b0;
    byte_done = 1'b0;
    case (hs_q)
      HS_IDLE: begin
        if (req && !tx_busy) begin
          fire = 1'b1;
          hs_d = HS_WAIT_HI;
        end
      end
      HS_WAIT_HI: if (tx_busy) hs_d = HS_WAIT_LO;
      HS_WAIT_LO: begin
        if (!tx_busy) begin
          byte_done = 1'b1;
          hs_d      = HS_IDLE;
        end
      end
      default: hs_d = HS_IDLE;
    endcase
  end

  // Registered pulse stage: byte is latched with the pulse and held until the next byte
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hs_q    <= HS_IDLE;
      pulse_q <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      hs_q    <= hs_d;
      pulse_q <= fire;
      if (fire) tx_data <= byte_in;
    end
  end

  // An abort must kill a pending pulse in the same cycle, not one cycle later
  assign tx_start = pulse_q & ~rst & ~clear;

endmodule

// File: rtl/result_sender.sv
// Frames the result buffer for the UART: header, big-endian element bytes,
// trailer. Define RESULT_SENDER_CHECKSUM_EN to insert an XOR checksum byte.
module result_sender
  import result_sender_pkg::*;
#(
  parameter int         DATA_W   = RESULT_W,
  parameter int         SIZE_W   = 4,
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF,
  parameter logic [7:0] TRL_BYTE = TRL_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              START,
  input  logic              CLEAR,
  input  logic [SIZE_W-1:0] VEC_SIZE,
  output logic [SIZE_W-1:0] RD_ADDR,
  output logic              RD_EN,
  input  logic [DATA_W-1:0] RD_DATA,
  output logic [7:0]        TX_DATA,
  output logic              TX_START,
  input  logic              TX_BUSY,
  output logic              BUSY,
  output logic              DONE
);

`ifdef RESULT_SENDER_CHECKSUM_EN
  localparam sender_state_t TAIL_S = CHK;
  logic [7:0] chk_q;
`else
  localparam sender_state_t TAIL_S = TRL;
`endif

  localparam logic [SIZE_W-1:0] ONE = {{(SIZE_W-1){1'b0}}, 1'b1};

  sender_state_t     state_q, state_d;
  logic [SIZE_W-1:0] size_q, idx_q;
  logic [DATA_W-1:0] elem_p1;
  logic [7:0]        tx_byte;
  logic              req, byte_done, last_elem;

  assign last_elem = (idx_q == size_q - ONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = HDR;
      HDR:     if (byte_done) state_d = (size_q == '0) ? TAIL_S : FETCH;
      FETCH:   state_d = RDWAIT;
      RDWAIT:  state_d = SEND_HI;
      SEND_HI: if (byte_done) state_d = SEND_LO;
      SEND_LO: if (byte_done) state_d = last_elem ? TAIL_S : FETCH;
`ifdef RESULT_SENDER_CHECKSUM_EN
      CHK:     if (byte_done) state_d = TRL;
`endif
      TRL:     if (byte_done) state_d = DONE_S;
      DONE_S:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req     = 1'b1;
    tx_byte = HDR_BYTE;
    case (state_q)
      HDR:     tx_byte = HDR_BYTE;
      SEND_HI: tx_byte = elem_p1[DATA_W-1 -: 8];
      SEND_LO: tx_byte = elem_p1[7:0];
`ifdef RESULT_SENDER_CHECKSUM_EN
      CHK:     tx_byte = chk_q;
`endif
      TRL:     tx_byte = TRL_BYTE;
      default: req = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || CLEAR) begin
      state_q <= IDLE;
      size_q  <= '0;
      idx_q   <= '0;
      elem_p1 <= '0;
`ifdef RESULT_SENDER_CHECKSUM_EN
      chk_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && START) begin
        size_q <= VEC_SIZE;
        idx_q  <= '0;
`ifdef RESULT_SENDER_CHECKSUM_EN
        chk_q  <= 8'h00;
`endif
      end
      // Read data stage: buffer output is valid the cycle after RD_EN
      if (state_q == RDWAIT) elem_p1 <= RD_DATA;
      if (state_q == SEND_LO && byte_done) idx_q <= idx_q + ONE;
`ifdef RESULT_SENDER_CHECKSUM_EN
      if (byte_done && state_q == SEND_HI) chk_q <= chk_q ^ elem_p1[DATA_W-1 -: 8];
      if (byte_done && state_q == SEND_LO) chk_q <= chk_q ^ elem_p1[7:0];
`endif
    end
  end

  tx_byte_hs u_hs (
    .clk      (clk),
    .rst      (rst),
    .clear    (CLEAR),
    .req      (req),
    .byte_in  (tx_byte),
    .tx_busy  (TX_BUSY),
    .tx_data  (TX_DATA),
    .tx_start (TX_START),
    .byte_done(byte_done)
  );

  assign RD_EN   = (state_q == FETCH);
  assign RD_ADDR = RD_EN ? idx_q : '0;
  assign BUSY    = (state_q != IDLE) && (state_q != DONE_S);
  assign DONE    = (state_q == DONE_S);

endmodule

// File: doc/result_sender.md
Name: result_sender

Overview:
- Drains the result vector produced by the matrix-vector engine back to the host, one byte at a time, through the UART transmitter.
- Mirrors the receive-side data feeder: the feeder writes bytes into the RAMs/PIPO; this block reads the result buffer and frames it for transmission.
- Sits between the result buffer (synchronous read port) and the UART TX byte interface. The top-level control FSM starts it.

Parameters:
- DATA_W, 16, width of one result element.
- SIZE_W, 4, width of the element-count / address.
- HDR_BYTE, 8'hFE, frame header byte.
- TRL_BYTE, 8'hEF, frame trailer byte.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, synchronous and active-high; one clock.
- START  input  1  one-cycle request to send a frame; sampled in IDLE only.
- CLEAR  input  1  synchronous abort; returns the block to IDLE.
- VEC_SIZE  input  SIZE_W  number of elements N to send; latched on an accepted START.
- RD_ADDR  output  SIZE_W  result buffer read address.
- RD_EN  output  1  read strobe; data is valid on RD_DATA one cycle later.
- RD_DATA  input  DATA_W  result buffer read data.
- TX_DATA  output  8  byte to transmit; held stable from TX_START until TX_BUSY falls.
- TX_START  output  1  one-cycle pulse requesting transmission of TX_DATA.
- TX_BUSY  input  1  UART busy; rises the cycle after TX_START and stays high until the byte is sent.
- BUSY  output  1  high from accepted START until DONE.
- DONE  output  1  one-cycle pulse after the trailer byte completes.

Behaviour:
- Reset: state=IDLE. RD_ADDR=0, RD_EN=0, TX_DATA=0, TX_START=0, BUSY=0, DONE=0. Latched size, element buffer and checksum are cleared.
- Priority, highest first: rst, CLEAR, normal operation. CLEAR clears the same registers as rst, in any state, and produces no DONE.
- Frame on the wire: HDR_BYTE, then for i=0..N-1 RD_DATA[i][15:8] followed by RD_DATA[i][7:0], then (optional checksum byte), then TRL_BYTE.
- States: IDLE -> HDR -> FETCH -> RDWAIT -> SEND_HI -> SEND_LO -> (next element FETCH | CHK | TRL) -> DONE_S -> IDLE.
- IDLE: START=1 latches VEC_SIZE, sets BUSY, and goes to HDR next cycle. START in any other state is ignored.
- N=0: header and trailer are sent with no elements; HDR goes directly to CHK or TRL.
- FETCH: RD_EN=1 and RD_ADDR=index for exactly one cycle.
- RDWAIT: RD_DATA is captured into a DATA_W element register at the end of this cycle.
- Byte send (HDR, SEND_HI, SEND_LO, CHK, TRL), per byte:
  - Drive TX_DATA and pulse TX_START for one cycle, but only while TX_BUSY=0.
  - Wait for TX_BUSY=1, then wait for TX_BUSY=0, then advance.
  - If TX_BUSY is already high on entry, hold without pulsing until it falls.
- Index increments after SEND_LO. When index = N-1 the next state is CHK or TRL; otherwise FETCH. Index width SIZE_W; N up to 15, no wrap.
- DONE_S: DONE=1 and BUSY falls in the same cycle; return to IDLE next cycle.
- Minimum latency from START to the first TX_START: 2 cycles (IDLE->HDR registered, then pulse).
- rst or CLEAR mid-byte: TX_START deasserts immediately. The UART's own completion of that byte is not tracked.

Optional Feature:
- Macro: RESULT_SENDER_CHECKSUM_EN.
- Defined: an 8-bit XOR accumulator, cleared at START, is updated with every element byte (header excluded). CHK state transmits it immediately before TRL_BYTE.
- Not defined: CHK state and the accumulator are absent. The frame length is 2N+2 bytes.

Decomposition:
- Definitions_Package holds:
  - the state enum typedef (sender_state_t);
  - HDR_BYTE and TRL_BYTE defaults;
  - the result element width constant shared with the MAC/result buffer.
- One natural sub-module: tx_byte_hs. It implements the pulse/wait-high/wait-low handshake for a single byte and returns a one-cycle byte_done to the FSM.

Test Plan:
- Bench UART model: asserts TX_BUSY the cycle after TX_START and holds it 10 cycles.
- Reset: hold rst 3 cycles -> all outputs 0, state IDLE; START during reset ignored.
- N=3, buffer {16'h1234, 16'hABCD, 16'h00FF}, no macro -> bytes FE 12 34 AB CD 00 FF EF; exactly 8 TX_START pulses; one DONE; BUSY low after.
- N=0 -> bytes FE EF; no RD_EN pulse; DONE after the second byte.
- Back-pressure: TX_BUSY forced high for 50 cycles when HDR is entered -> no TX_START until it falls, then FE sent once.
- CLEAR asserted during the second element's SEND_LO, N=4 -> TX_START stops, no DONE, IDLE next cycle; a following START sends the full frame from index 0.
- With RESULT_SENDER_CHECKSUM_EN, N=2, {16'h0102, 16'h0304} -> bytes FE 01 02 03 04 04 EF (XOR=0x04).
